// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder and subtractor).
// Holds the FSM state encoding and the default operand width.
package serial_arith_pkg;

  localparam int N = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit subtractor cell: d = x - y - bin, with the borrow out in bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic xy_eq;

  assign xy_eq = ~(x ^ y);
  assign d     = x ^ y ^ bin;
  // Borrow when x is 0 and y is 1, or when the bits match and a borrow is pending.
  assign bo    = (~x & y) | (xy_eq & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock.
// Start/ready handshake shared with the serial adder; done pulses for one cycle per result.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int N  = serial_arith_pkg::N,
  parameter int CW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
);

  state_t          state_q;
  logic [N-1:0]    sa_q;
  logic [N-1:0]    sb_q;
  logic [N-1:0]    wr_q;
  logic [CW-1:0]   cnt_q;
  logic            borrow_q;
  logic            ready_q;
  logic            done_q;
  logic [N-1:0]    diff_q;
  logic            bout_q;

  logic            bit_d;
  logic            borrow_d;
  logic [N-1:0]    wr_d;
  logic            last_bit;

  full_subtractor u_cell (
    .x   (sa_q[0]),
    .y   (sb_q[0]),
    .bin (borrow_q),
    .d   (bit_d),
    .bo  (borrow_d)
  );

  // Result bits enter at the MSB so the LSB lands at bit 0 after N shifts.
  assign wr_d     = {bit_d, wr_q[N-1:1]};
  assign last_bit = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sa_q     <= a;
            sb_q     <= b;
            wr_q     <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            ready_q  <= 1'b0;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          sa_q     <= {1'b0, sa_q[N-1:1]};
          sb_q     <= {1'b0, sb_q[N-1:1]};
          wr_q     <= wr_d;
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last_bit) begin
            diff_q  <= wr_d;
            bout_q  <= borrow_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (N=4) with hand-computed expected results.
module tb_serial_subtractor;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ready;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.N(N), .CW(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation and follow it to completion; start is dropped after acceptance.
  task automatic run_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic [N-1:0] exp_d, input logic exp_b);
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, ready, 0);
    for (int k = 1; k < N; k++) begin
      tick();
      chk({tag, "_nodone"}, done, 0);
    end
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_diff"}, diff, exp_d);
    chk({tag, "_bout"}, bout, exp_b);
    chk({tag, "_rdy_lo"}, ready, 0);
    tick();
    chk({tag, "_done_lo"}, done, 0);
    chk({tag, "_rdy_hi"}, ready, 1);
    chk({tag, "_diff_hold"}, diff, exp_d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b1; a = 4'b1101; b = 4'b0110;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_ready", ready, 1);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      chk("rst_bout", bout, 0);
    end
    rst = 1'b1; start = 1'b0;
    tick();

    run_op("basic", 4'b1011, 4'b0011, 4'b1000, 1'b0);
    run_op("borrow", 4'b0011, 4'b1011, 4'b1000, 1'b1);
    run_op("zero_m1", 4'b0000, 4'b0001, 4'b1111, 1'b1);
    run_op("equal", 4'b0101, 4'b0101, 4'b0000, 1'b0);
    run_op("min_max", 4'b0000, 4'b1111, 4'b0001, 1'b1);

    // Start requests during SHIFT must be ignored.
    a = 4'b0110; b = 4'b0010; start = 1'b1;
    tick();
    a = 4'b1111; b = 4'b0000;
    for (int k = 1; k < N; k++) begin
      tick();
      chk("busy_nodone", done, 0);
    end
    start = 1'b0;
    tick();
    chk("busy_done", done, 1);
    chk("busy_diff", diff, 4'b0100);
    chk("busy_bout", bout, 0);
    for (int k = 0; k < N + 2; k++) begin
      tick();
      chk("busy_no2nd", done, 0);
    end
    chk("busy_idle", ready, 1);

    // Abort mid-operation with reset.
    a = 4'b1001; b = 4'b0100; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    for (int k = 0; k < N + 2; k++) begin
      tick();
      chk("abort_nodone", done, 0);
    end
    run_op("after_abort", 4'b1001, 4'b0100, 4'b0101, 1'b0);

    // start held high: one result every N+2 cycles.
    a = 4'b0111; b = 4'b0001; start = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k < N; k++) begin
        tick();
        chk("b2b_nodone", done, 0);
      end
      tick();
      chk("b2b_done", done, 1);
      chk("b2b_diff", diff, 4'b0110);
      chk("b2b_bout", bout, 0);
      tick();
      chk("b2b_done_lo", done, 0);
      chk("b2b_ready", ready, 1);
      tick();
      chk("b2b_reaccept", ready, 0);
    end
    start = 1'b0;
    for (int k = 0; k < N + 2; k++) tick();
    chk("end_idle", ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
